// File: rtl/alu_share_arbiter_if.sv
// Operand/result bundle between the two requesters, the shared ALU arbiter
// and the result consumer.
interface alu_share_arbiter_if;
    logic       req0;
    logic       req1;
    logic [2:0] a0;
    logic [2:0] b0;
    logic [2:0] a1;
    logic [2:0] b1;
    logic       op0;
    logic       op1;
    logic       gnt0;
    logic       gnt1;
    logic [3:0] y;
    logic       y_valid;
    logic       y_id;
    logic       busy;

    modport master (
        output req0, req1, a0, b0, a1, b1, op0, op1,
        input  gnt0, gnt1, y, y_valid, y_id, busy
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1, op0, op1,
        output gnt0, gnt1, y, y_valid, y_id, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one 3-bit add/absdiff unit between two requesters,
// sequenced IDLE -> CALC -> RESP so that one operation completes every 3 cycles.
module alu_share_arbiter (
    input  logic                clk,
    input  logic                reset,
    alu_share_arbiter_if.slave  bus
);
    localparam int unsigned OpW  = 3;
    localparam int unsigned ResW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              win_q, win_d;
    logic [OpW-1:0]    a_q, a_d;
    logic [OpW-1:0]    b_q, b_d;
    logic              op_q, op_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic [ResW-1:0]   y_q, y_d;
    logic              y_valid_q, y_valid_d;
    logic              y_id_q, y_id_d;
    logic              busy_q, busy_d;

    logic              winner_c;
    logic [OpW-1:0]    diff_c;
    logic [ResW-1:0]   result_c;

    // On a tie the requester that was not served last wins
    always_comb begin
        if (bus.req0 && bus.req1) begin
            winner_c = ~last_q;
        end else begin
            winner_c = bus.req1;
        end
    end

    // Shared arithmetic on the captured operands
    always_comb begin
        diff_c = (a_q >= b_q) ? (a_q - b_q) : (b_q - a_q);
        if (op_q) begin
            result_c = ResW'(diff_c);
        end else begin
            result_c = ResW'(a_q) + ResW'(b_q);
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        win_d     = win_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        y_d       = y_q;
        y_valid_d = 1'b0;
        y_id_d    = y_id_q;
        busy_d    = busy_q;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.req0 || bus.req1) begin
                    win_d   = winner_c;
                    last_d  = winner_c;
                    a_d     = winner_c ? bus.a1  : bus.a0;
                    b_d     = winner_c ? bus.b1  : bus.b0;
                    op_d    = winner_c ? bus.op1 : bus.op0;
                    gnt0_d  = ~winner_c;
                    gnt1_d  = winner_c;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                y_d       = result_c;
                y_id_d    = win_q;
                y_valid_d = 1'b1;
                busy_d    = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight operation
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            win_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_id_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            win_q     <= win_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            y_id_q    <= y_id_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.y_id    = y_id_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomized checks of alu_share_arbiter against a cycle-level
// transaction model of the shared ALU service.
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    alu_share_arbiter_if bus ();

    alu_share_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cycles since grant (0 = idle), round-robin history, pending result
    int m_phase = 0;
    int m_last  = 1;
    int m_win   = 0;
    int m_res   = 0;
    int e_gnt0 = 0, e_gnt1 = 0, e_y = 0, e_yv = 0, e_yid = 0, e_busy = 0;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int alu(input int a, input int b, input int op);
        if (op != 0) return (a > b) ? a - b : b - a;
        return a + b;
    endfunction

    task automatic model_update();
        e_gnt0 = 0;
        e_gnt1 = 0;
        e_yv   = 0;
        if (!reset) begin
            m_phase = 0; m_last = 1;
            e_y = 0; e_yid = 0; e_busy = 0;
        end else if (m_phase == 0) begin
            e_busy = 0;
            if (bus.req0 || bus.req1) begin
                if (bus.req0 && bus.req1) m_win = 1 - m_last;
                else                      m_win = bus.req1 ? 1 : 0;
                if (m_win == 1) m_res = alu(int'(bus.a1), int'(bus.b1), int'(bus.op1));
                else            m_res = alu(int'(bus.a0), int'(bus.b0), int'(bus.op0));
                if (m_win == 1) e_gnt1 = 1; else e_gnt0 = 1;
                m_last  = m_win;
                m_phase = 1;
                e_busy  = 1;
            end
        end else if (m_phase == 1) begin
            e_y = m_res; e_yid = m_win; e_yv = 1; e_busy = 1;
            m_phase = 2;
        end else begin
            e_busy  = 0;
            m_phase = 0;
        end
    endtask

    // Advance one clock: predict from the inputs seen at the edge, then compare
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        chk("gnt0",    4'(bus.gnt0),    4'(e_gnt0));
        chk("gnt1",    4'(bus.gnt1),    4'(e_gnt1));
        chk("y",       bus.y,           4'(e_y));
        chk("y_valid", 4'(bus.y_valid), 4'(e_yv));
        chk("y_id",    4'(bus.y_id),    4'(e_yid));
        chk("busy",    4'(bus.busy),    4'(e_busy));
        chk("gnt_mutex", 4'(bus.gnt0 & bus.gnt1), 4'd0);
    endtask

    task automatic drive0(input logic r, input int a, input int b, input logic op);
        bus.req0 = r; bus.a0 = 3'(a); bus.b0 = 3'(b); bus.op0 = op;
    endtask

    task automatic drive1(input logic r, input int a, input int b, input logic op);
        bus.req1 = r; bus.a1 = 3'(a); bus.b1 = 3'(b); bus.op1 = op;
    endtask

    // One full operation through requester 0 with an explicit expected result
    task automatic op0_once(input string tag, input int a, input int b, input logic op, input int exp);
        drive0(1'b1, a, b, op);
        step();
        chk({tag, "_gnt"}, 4'(bus.gnt0), 4'd1);
        bus.req0 = 1'b0;
        step();
        chk(tag, bus.y, 4'(exp));
        step();
    endtask

    initial begin
        reset = 1'b0;
        drive0(1'b1, 1, 2, 1'b0);
        drive1(1'b1, 3, 4, 1'b0);

        // Reset held with both requests high
        step();
        step();
        chk("rst_y", bus.y, 4'd0);
        chk("rst_busy", 4'(bus.busy), 4'd0);
        reset = 1'b1;
        step();
        chk("rst_first_gnt0", 4'(bus.gnt0), 4'd1);
        drive0(1'b0, 0, 0, 1'b0);
        drive1(1'b0, 0, 0, 1'b0);
        step(); step(); step();

        // Single add through requester 0
        drive0(1'b1, 2, 1, 1'b0);
        step();
        chk("add_gnt0", 4'(bus.gnt0), 4'd1);
        bus.req0 = 1'b0;
        step();
        chk("add_y", bus.y, 4'd3);
        chk("add_yv", 4'(bus.y_valid), 4'd1);
        step();
        chk("add_busy_done", 4'(bus.busy), 4'd0);

        // Absolute difference through requester 1
        drive1(1'b1, 3, 6, 1'b1);
        step();
        chk("abs_gnt1", 4'(bus.gnt1), 4'd1);
        bus.req1 = 1'b0;
        step();
        chk("abs_y", bus.y, 4'd3);
        chk("abs_id", 4'(bus.y_id), 4'd1);
        step();
        drive1(1'b1, 5, 3, 1'b1);
        step();
        bus.req1 = 1'b0;
        step();
        chk("abs2_y", bus.y, 4'd2);
        step();

        // Contention: both held, grants alternate every 3 cycles
        drive0(1'b1, 7, 2, 1'b0);
        drive1(1'b1, 5, 3, 1'b0);
        step(); chk("cont_g0", 4'(bus.gnt0), 4'd1);
        step(); chk("cont_y0", bus.y, 4'd9);
        step();
        step(); chk("cont_g1", 4'(bus.gnt1), 4'd1);
        step(); chk("cont_y1", bus.y, 4'd8);
        step();
        step(); chk("cont_g0b", 4'(bus.gnt0), 4'd1);
        drive0(1'b0, 0, 0, 1'b0);
        drive1(1'b0, 0, 0, 1'b0);
        step(); step(); step();

        // Result range bounds
        op0_once("max_add", 7, 7, 1'b0, 14);
        op0_once("abs_eq", 4, 4, 1'b1, 0);
        op0_once("abs_0_7", 0, 7, 1'b1, 7);
        op0_once("abs_7_0", 7, 0, 1'b1, 7);

        // Reset during CALC discards the operation
        drive0(1'b1, 6, 5, 1'b0);
        step();
        drive1(1'b1, 1, 1, 1'b0);
        reset = 1'b0;
        step();
        chk("midrst_yv", 4'(bus.y_valid), 4'd0);
        chk("midrst_y", bus.y, 4'd0);
        reset = 1'b1;
        step();
        chk("midrst_gnt0", 4'(bus.gnt0), 4'd1);
        drive0(1'b0, 0, 0, 1'b0);
        drive1(1'b0, 0, 0, 1'b0);
        step(); step();

        // Randomized requesters: hold until granted, then drop or re-request
        for (int i = 0; i < 800; i++) begin
            reset = ($urandom_range(0, 63) != 0);
            if (bus.req0) begin
                if (bus.gnt0 ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 15) == 0))
                    bus.req0 = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                drive0(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            end
            if (bus.req1) begin
                if (bus.gnt1 ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 15) == 0))
                    bus.req1 = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                drive1(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
